mem_stage_lsu: RTL

- MEM-stage load/store unit. Consumes the mem_* fields registered by the EX/MEM pipeline register and drives a valid/ready data bus.
- Performs store byte-lane steering and load extraction with sign/zero extension.
- Detects misaligned accesses and raises bus-error exceptions, including on timeout.
- Registers the MEM/WB writeback fields. Asserts mem_stall so pipeline control freezes EX/MEM and the earlier stages while an access is outstanding.

---
 rtl/mem_stage_lsu.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage load/store unit with valid/ready data bus
// Store lane steering, load extraction, misalignment/bus-error exceptions and MEM/WB register.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_pc,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_rs2_val_for_store,
  input  logic [4:0]  mem_rd_addr,
  input  logic        mem_reg_write,
  input  logic        mem_mem_read,
  input  logic        mem_mem_write,
  input  logic [1:0]  mem_wb_sel,
  input  logic [1:0]  mem_load_size,
  input  logic [1:0]  mem_store_size,
  input  logic        mem_load_signed,
  input  logic [31:0] mem_wb_candidate,
  output logic        dbus_req_valid,
  input  logic        dbus_req_ready,
  output logic [31:0] dbus_addr,
  output logic        dbus_we,
  output logic [3:0]  dbus_wstrb,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_rsp_valid,
  input  logic        dbus_rsp_err,
  input  logic [31:0] dbus_rdata,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd_addr,
  output logic        wb_reg_write,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_pc,
  output logic [31:0] exc_tval
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state, state_next;
  logic [CW-1:0] count;
  logic          access, is_load, misaligned, timeout;
  logic [1:0]    size, offset;
  logic [3:0]    store_strb;
  logic [31:0]   store_data, shifted, load_data, wb_value;
  logic          req_c, stall_c, complete, exc_c;
  logic [1:0]    cause_c;

  // A simultaneous read and write is treated as a load.
  assign access  = mem_mem_read | mem_mem_write;
  assign is_load = mem_mem_read;
  assign size    = is_load ? mem_load_size : mem_store_size;
  assign offset  = mem_alu_result[1:0];
  assign misaligned = access & (((size == 2'b01) & offset[0]) | (size[1] & (offset != 2'b00)));
  assign timeout = (count == COUNT_LAST);

  always_comb begin
    store_data = mem_rs2_val_for_store;
    store_strb = 4'b1111;
    case (mem_store_size)
      2'b00: begin
        store_data = {4{mem_rs2_val_for_store[7:0]}};
        store_strb = 4'b0001 << offset;
      end
      2'b01: begin
        store_data = {2{mem_rs2_val_for_store[15:0]}};
        store_strb = 4'b0011 << {offset[1], 1'b0};
      end
      default: ;
    endcase
  end

  assign dbus_addr  = {mem_alu_result[31:2], 2'b00};
  assign dbus_we    = mem_mem_write & ~is_load;
  assign dbus_wstrb = dbus_we ? store_strb : 4'b0000;
  assign dbus_wdata = store_data;

  // The byte offset stays valid through WAIT because EX/MEM is frozen by mem_stall.
  always_comb begin
    shifted   = dbus_rdata >> {offset, 3'b000};
    load_data = shifted;
    case (mem_load_size)
      2'b00:   load_data = {{24{mem_load_signed & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{mem_load_signed & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  assign wb_value = (mem_wb_sel == 2'b01) ? load_data : mem_wb_candidate;

  always_comb begin
    state_next = state;
    req_c      = 1'b0;
    stall_c    = 1'b0;
    complete   = 1'b0;
    exc_c      = 1'b0;
    cause_c    = 2'b00;
    case (state)
      IDLE: begin
        if (access && !misaligned) begin
          req_c      = 1'b1;
          stall_c    = 1'b1;
          state_next = dbus_req_ready ? WAIT : REQ;
        end else if (misaligned) begin
          complete = 1'b1;
          exc_c    = 1'b1;
          cause_c  = is_load ? 2'b01 : 2'b10;
        end else begin
          complete = 1'b1;
        end
      end
      REQ: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (dbus_req_ready) state_next = WAIT;
      end
      WAIT: begin
        stall_c = ~dbus_rsp_valid & ~timeout;
        if (dbus_rsp_valid) begin
          complete   = 1'b1;
          exc_c      = dbus_rsp_err;
          cause_c    = dbus_rsp_err ? 2'b11 : 2'b00;
          state_next = IDLE;
        end else if (timeout) begin
          complete   = 1'b1;
          exc_c      = 1'b1;
          cause_c    = 2'b11;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign dbus_req_valid = req_c & ~rst;
  assign mem_stall      = stall_c & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= (state == WAIT) ? count + CW'(1) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_rd_addr   <= '0;
      wb_reg_write <= 1'b0;
      wb_data      <= '0;
      exc_valid    <= 1'b0;
      exc_cause    <= '0;
      exc_pc       <= '0;
      exc_tval     <= '0;
    end else begin
      wb_valid  <= complete;
      exc_valid <= exc_c;
      if (complete) begin
        wb_rd_addr   <= mem_rd_addr;
        wb_reg_write <= mem_reg_write & (|mem_rd_addr) & ~exc_c;
        wb_data      <= wb_value;
      end
      if (exc_c) begin
        exc_cause <= cause_c;
        exc_pc    <= mem_pc;
        exc_tval  <= mem_alu_result;
      end
    end
  end

endmodule
